dg_mc_fifo: RTL

Multi-channel synchronous FIFO for the data-generation control path. It holds CH_NUM independent queues behind one shared write port. Each queue has its own read port, occupancy count, programmable almost-full/almost-empty thresholds, per-channel flush, and sticky overflow/underflow flags. It replaces per-channel single FIFOs between the packet generator and the port-injection logic. It supports first-word fall-through (FWFT) and registered-read modes.

---
 rtl/dg_mc_fifo_if.sv | 36 +++
 rtl/dg_mc_fifo.sv | 99 +++++++++
 2 files changed

// File: rtl/dg_mc_fifo_if.sv
// Bundle of the shared write port, per-channel read/flush controls and
// per-channel status/data outputs for the multi-channel FIFO.
interface dg_mc_fifo_if #(
    parameter int CH_NUM     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int NW = ADDR_WIDTH + 1;

    logic                         wr_en;
    logic [CW-1:0]                wr_ch;
    logic [DATA_WIDTH-1:0]        din;
    logic [CH_NUM-1:0]            rd_en;
    logic [CH_NUM-1:0]            flush;
    logic [NW-1:0]                af_thresh;
    logic [NW-1:0]                ae_thresh;
    logic [CH_NUM*DATA_WIDTH-1:0] dout;
    logic [CH_NUM-1:0]            full;
    logic [CH_NUM-1:0]            empty;
    logic [CH_NUM-1:0]            almost_full;
    logic [CH_NUM-1:0]            almost_empty;
    logic [CH_NUM*NW-1:0]         count;
    logic [CH_NUM-1:0]            overflow;
    logic [CH_NUM-1:0]            underflow;

    modport master (
        output wr_en, wr_ch, din, rd_en, flush, af_thresh, ae_thresh,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_ch, din, rd_en, flush, af_thresh, ae_thresh,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/dg_mc_fifo.sv
// Multi-channel synchronous FIFO: CH_NUM independent queues behind one shared
// write port, each with its own pop, flush, thresholds and sticky error flags.
module dg_mc_fifo #(
    parameter int CH_NUM     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT_EN    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dg_mc_fifo_if.slave  bus
);
    localparam int CW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int NW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [NW-1:0]         wptr_q, wptr_d;
        logic [NW-1:0]         rptr_q, rptr_d;
        logic                  ovf_q, ovf_d;
        logic                  udf_q, udf_d;
        logic [DATA_WIDTH-1:0] hold_q, hold_d;
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        logic [NW-1:0]         cnt;
        logic                  is_full, is_empty;
        logic                  wr_hit, wr_acc, rd_acc;
        logic [DATA_WIDTH-1:0] rd_data;

        assign cnt      = wptr_q - rptr_q;
        assign is_empty = (wptr_q == rptr_q);
        assign is_full  = (wptr_q[NW-1] != rptr_q[NW-1]) &&
                          (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

        // Out-of-range wr_ch matches no channel, so such writes vanish with no flag.
        assign wr_hit  = bus.wr_en && (bus.wr_ch == CW'(c));
        assign wr_acc  = wr_hit && !is_full && !bus.flush[c];
        assign rd_acc  = bus.rd_en[c] && !is_empty && !bus.flush[c];
        assign rd_data = mem_q[rptr_q[ADDR_WIDTH-1:0]];

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            ovf_d  = ovf_q;
            udf_d  = udf_q;
            hold_d = hold_q;
            if (bus.flush[c]) begin
                wptr_d = '0;
                rptr_d = '0;
                ovf_d  = 1'b0;
                udf_d  = 1'b0;
            end else begin
                if (wr_acc) wptr_d = wptr_q + 1'b1;
                if (rd_acc) begin
                    rptr_d = rptr_q + 1'b1;
                    hold_d = rd_data;
                end
                if (wr_hit && is_full)          ovf_d = 1'b1;
                if (bus.rd_en[c] && is_empty)   udf_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
                hold_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                ovf_q  <= ovf_d;
                udf_q  <= udf_d;
                hold_q <= hold_d;
            end
        end

        // Storage is not reset; contents are only reachable through the pointers.
        always_ff @(posedge clk) begin
            if (wr_acc) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.din;
        end

        // hold_q is the last popped word: the FWFT idle value and the registered-read output.
        if (FWFT_EN != 0) begin : g_fwft
            assign bus.dout[c*DATA_WIDTH +: DATA_WIDTH] = is_empty ? hold_q : rd_data;
        end else begin : g_reg
            assign bus.dout[c*DATA_WIDTH +: DATA_WIDTH] = hold_q;
        end

        assign bus.count[c*NW +: NW] = cnt;
        assign bus.full[c]           = is_full;
        assign bus.empty[c]          = is_empty;
        assign bus.almost_full[c]    = (cnt >= bus.af_thresh);
        assign bus.almost_empty[c]   = (cnt <= bus.ae_thresh);
        assign bus.overflow[c]       = ovf_q;
        assign bus.underflow[c]      = udf_q;
    end
endmodule
